// File: rtl/xor_parity_pkg.sv
// Shared types and constants for the serial parity frame checker.
package xor_parity_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam int                  ERRCNT_W   = 8;
  localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'd255;

endpackage

// File: rtl/xor_gate.sv
// Two-input XOR cell from the shared standard-cell wrapper library.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_parity_frame.sv
// Serial frame parity checker: DATA_BITS data bits then one parity bit.
// Define XOR_PARITY_ERRCNT_EN to add the saturating err_cnt output.
//
// state    | meaning
// S_IDLE   | waiting for start, results from last frame held
// S_DATA   | accumulating data bits into acc
// S_PARITY | waiting for the received parity bit
// S_DONE   | par/err valid until done_ack
module xor_parity_frame
  import xor_parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter bit ODD       = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                din,
  input  logic                din_valid,
  input  logic                done_ack,
  output logic                din_ready,
  output logic                par,
  output logic                err,
  output logic                done,
  output logic                busy
`ifdef XOR_PARITY_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_cnt
`endif
);

  localparam int               CNT_W    = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             acc_q;
  logic             acc_nxt;
  logic             xfer;

  assign xfer = din_valid & din_ready;

  // Shared by the data accumulate and the parity compare.
  xor_gate u_xor (
    .a (acc_q),
    .b (din),
    .y (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start)                      state_d = S_DATA;
      S_DATA:   if (xfer && (cnt_q == CNT_LAST)) state_d = S_PARITY;
      S_PARITY: if (xfer)                       state_d = S_DONE;
      S_DONE:   if (done_ack)                   state_d = S_IDLE;
      default:                                  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    din_ready = (state_q == S_DATA) || (state_q == S_PARITY);
    done      = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
      cnt_q <= '0;
      par   <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q <= 1'b0;
            cnt_q <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (xfer) begin
            par <= acc_q ^ ODD;
            err <= acc_nxt ^ ODD;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef XOR_PARITY_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((state_q == S_PARITY) && xfer && (acc_nxt ^ ODD)
                 && (err_cnt != ERRCNT_MAX)) begin
      err_cnt <= err_cnt + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_xor_parity_frame.sv
// Directed bench for xor_parity_frame; even and odd instances share stimulus.
module tb_xor_parity_frame;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic done_ack = 1'b0;
  logic din_ready, par, err, done, busy;
  logic din_ready_o, par_o, err_o, done_o, busy_o;
`ifdef XOR_PARITY_ERRCNT_EN
  logic [7:0] err_cnt, err_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_errcnt = 0;

  always #5 clk = ~clk;

  xor_parity_frame #(.DATA_BITS(8), .ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .done_ack(done_ack), .din_ready(din_ready), .par(par), .err(err),
    .done(done), .busy(busy)
`ifdef XOR_PARITY_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  xor_parity_frame #(.DATA_BITS(8), .ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .start(start), .din(din), .din_valid(din_valid),
    .done_ack(done_ack), .din_ready(din_ready_o), .par(par_o), .err(err_o),
    .done(done_o), .busy(busy_o)
`ifdef XOR_PARITY_ERRCNT_EN
    , .err_cnt(err_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame bits go out MSB first; leaves both DUTs in DONE with done_ack low.
  task automatic send_frame(input logic [7:0] d, input logic pb, input bit gaps,
                            input bit do_start, input logic ep, input logic ee,
                            input string name);
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n_tests++;
    if (busy !== 1'b1 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s frame_start busy=%b din_ready=%b required 1/1", name, busy, din_ready);
    end
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        din = ~d[7-i];
        din_valid = 1'b0;
        tick();
      end
      din = d[7-i];
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    n_tests++;
    if (done !== 1'b0 || din_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s before_parity done=%b din_ready=%b required 0/1", name, done, din_ready);
    end
    if (gaps) tick();
    din = pb;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    if (ee && exp_errcnt < 255) exp_errcnt++;
    n_tests++;
    if (done !== 1'b1 || par !== ep || err !== ee || din_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s result done=%b par=%b err=%b rdy=%b required 1/%b/%b/0",
               name, done, par, err, din_ready, ep, ee);
    end
    n_tests++;
    if (done_o !== 1'b1 || par_o !== ~ep || err_o !== ~ee) begin
      n_fail++;
      $display("FAIL %s odd_result done=%b par=%b err=%b required 1/%b/%b",
               name, done_o, par_o, err_o, ~ep, ~ee);
    end
`ifdef XOR_PARITY_ERRCNT_EN
    n_tests++;
    if (err_cnt !== 8'(exp_errcnt)) begin
      n_fail++;
      $display("FAIL %s err_cnt got=%0d required=%0d", name, err_cnt, exp_errcnt);
    end
`endif
  endtask

  task automatic ack(input string name);
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ack busy=%b done=%b busy_odd=%b required 0/0/0", name, busy, done, busy_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_errcnt = 0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || din_ready !== 1'b0 || par !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b rdy=%b par=%b err=%b required all 0",
               busy, done, din_ready, par, err);
    end
`ifdef XOR_PARITY_ERRCNT_EN
    n_tests++;
    if (err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_errcnt got=%0d required=0", err_cnt);
    end
`endif
  endtask

  task automatic test_even_ok();
    send_frame(8'b1011_0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "even_ok");
    ack("even_ok");
  endtask

  task automatic test_parity_error();
    send_frame(8'b1011_0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "parity_err");
    ack("parity_err");
    n_tests++;
    if (par !== 1'b0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_hold par=%b err=%b required 0/1", par, err);
    end
  endtask

  task automatic test_gaps();
    send_frame(8'b1011_0010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "gaps_ok");
    ack("gaps_ok");
    send_frame(8'b1110_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, "gaps_odd_data");
    ack("gaps_odd_data");
  endtask

  task automatic test_hold_ack();
    send_frame(8'b1011_0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "hold");
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if (done !== 1'b1 || par !== 1'b0 || err !== 1'b1 || din_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d done=%b par=%b err=%b rdy=%b required 1/0/1/0",
                 i, done, par, err, din_ready);
      end
    end
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_ack_idle busy=%b done=%b required 0/0", busy, done);
    end
    tick();
    start = 1'b0;
    send_frame(8'b0000_0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "hold_next");
    ack("hold_next");
  endtask

  task automatic test_reset_midframe();
    start = 1'b1;
    tick();
    start = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = (i != 3);
      tick();
    end
    din_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_errcnt = 0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || din_ready !== 1'b0 || par !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset busy=%b done=%b rdy=%b par=%b err=%b required all 0",
               busy, done, din_ready, par, err);
    end
    send_frame(8'b1000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "after_reset");
    ack("after_reset");
  endtask

`ifdef XOR_PARITY_ERRCNT_EN
  task automatic test_errcnt_sat();
    for (int i = 0; i < 260; i++) begin
      send_frame(8'b1011_0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "errcnt");
      ack("errcnt");
    end
    n_tests++;
    if (err_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL errcnt_sat got=%0d required=255", err_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_errcnt = 0;
    n_tests++;
    if (err_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL errcnt_reset got=%0d required=0", err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_even_ok();
    test_parity_error();
    test_gaps();
    test_hold_ack();
    test_reset_midframe();
`ifdef XOR_PARITY_ERRCNT_EN
    test_errcnt_sat();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
